// File: rtl/osum_deskew_drain.sv
`default_nettype none
// ============================================================================
// Module   : osum_deskew_drain
// Purpose  : Output-side drain for the systolic array. Realigns the skewed
//            bottom-edge partial sums (column c lags column 0 by c cycles)
//            into one row vector. Complete rows are buffered in a small FIFO
//            and released downstream under a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module osum_deskew_drain #(
  parameter int COLS  = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic [COLS*WIDTH-1:0]          i_data,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [COLS*WIDTH-1:0]          o_data,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_overflow
);

  localparam int DW = COLS * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // Skew stage: free-running delay lines, no enable and no backpressure.
  // --------------------------------------------------------------------------
  logic [DW-1:0] aligned_data;
  logic          aligned_valid;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int DLY = COLS - 1 - c;
    if (DLY == 0) begin : g_pass
      // The last column arrives already aligned with the rest of its row.
      assign aligned_data[c*WIDTH +: WIDTH] = i_data[c*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] dly_q [DLY];
      // Delay column c by the number of cycles it leads the last column.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= i_data[c*WIDTH +: WIDTH];
          for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_data[c*WIDTH +: WIDTH] = dly_q[DLY-1];
    end
  end

  logic vld_q [COLS-1];

  // Carry the column-0 valid alongside the data so it marks the aligned row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < COLS - 1; k++) vld_q[k] <= 1'b0;
    end else begin
      vld_q[0] <= i_valid;
      for (int k = 1; k < COLS - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign aligned_valid = vld_q[COLS-2];

  // --------------------------------------------------------------------------
  // Row FIFO
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          push;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a row
  // when the head is leaving.
  assign pop  = (count_q != '0) && o_ready;
  assign push = aligned_valid && ((count_q != C_FULL) || pop);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (aligned_valid && !push) ovf_d = 1'b1;
  end

  // Control registers; reset discards every stored and in-flight row.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Row storage; contents are left as-is on reset since the empty FIFO
  // masks them on the output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= aligned_data;
  end

  assign o_valid    = (count_q != '0);
  assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_osum_deskew_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_osum_deskew_drain
// Purpose  : Self-checking bench for osum_deskew_drain. Rows are launched
//            with the column skew the array produces; a queue-based model
//            of the row FIFO predicts every output.
// Revision : 1.0  initial release
// ============================================================================
module tb_osum_deskew_drain;

  localparam int COLS  = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = COLS * WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference state: launch history (index k = launched k cycles ago),
  // the queue of stored rows and the sticky drop flag.
  bit            hv [COLS];
  logic [DW-1:0] hr [COLS];
  logic [DW-1:0] mq [$];
  bit            movf;

  osum_deskew_drain #(.COLS(COLS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  // One cycle: drive skewed columns, advance the model, move to next negedge.
  task automatic tick(input bit v, input logic [DW-1:0] row, input bit rdy);
    int sz;
    bit pop;
    for (int k = COLS - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hr[k] = hr[k-1];
    end
    hv[0] = v;
    hr[0] = row;
    i_valid = v;
    o_ready = rdy;
    for (int c = 0; c < COLS; c++)
      i_data[c*WIDTH +: WIDTH] = hv[c] ? hr[c][c*WIDTH +: WIDTH] : WIDTH'($urandom);
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (hv[COLS-1]) begin
      if (sz < DEPTH || pop) mq.push_back(hr[COLS-1]);
      else movf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b1;
    i_data = rand_row();
    o_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < COLS; k++) begin
      hv[k] = 1'b0;
      hr[k] = '0;
    end
    mq.delete();
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
    n_chk++; if (o_data !== '0) $display("FAIL reset_data: got %h want 0", o_data); else n_pass++;
    n_chk++; if (o_count !== '0) $display("FAIL reset_count: got %0d want 0", o_count); else n_pass++;
    n_chk++; if (o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", o_overflow); else n_pass++;
  endtask

  task automatic test_single_row();
    logic [DW-1:0] row;
    row = {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0001};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      n_chk++;
      if (o_valid !== (k == 4)) $display("FAIL single_valid cyc%0d: got %b want %b", k, o_valid, (k == 4));
      else n_pass++;
      if (k == 4) begin
        n_chk++;
        if (o_data !== row) $display("FAIL single_data: got %h want %h", o_data, row);
        else n_pass++;
      end
      tick(k == 0, row, 1'b1);
    end
    n_chk++; if (o_count !== '0) $display("FAIL single_count: got %0d want 0", o_count); else n_pass++;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] rows [8];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < COLS; c++) rows[r][c*WIDTH +: WIDTH] = WIDTH'(r * 16 + c);
    do_reset();
    for (int k = 0; k < 15; k++) begin
      n_chk++;
      if (o_valid !== (k >= 4 && k < 12)) $display("FAIL stream_valid cyc%0d: got %b want %b", k, o_valid, (k >= 4 && k < 12));
      else n_pass++;
      if (k >= 4 && k < 12) begin
        n_chk++;
        if (o_data !== rows[k-4]) $display("FAIL stream_data cyc%0d: got %h want %h", k, o_data, rows[k-4]);
        else n_pass++;
      end
      n_chk++; if (o_overflow !== 1'b0) $display("FAIL stream_ovf cyc%0d: got %b want 0", k, o_overflow); else n_pass++;
      tick(k < 8, (k < 8) ? rows[k] : rand_row(), 1'b1);
    end
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] rows [5];
    for (int r = 0; r < 5; r++) rows[r] = rand_row();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k >= 4 && o_valid) begin
        n_chk++;
        if (o_data !== rows[0]) $display("FAIL stall_head cyc%0d: got %h want %h", k, o_data, rows[0]);
        else n_pass++;
      end
      if (k == 7) begin
        n_chk++; if (o_count !== CW'(4)) $display("FAIL stall_count: got %0d want 4", o_count); else n_pass++;
        n_chk++; if (o_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", o_valid); else n_pass++;
      end
      tick(k < 4 || k == 8, (k < 4) ? rows[k] : rows[4], 1'b0);
    end
    n_chk++; if (o_overflow !== 1'b1) $display("FAIL stall_ovf: got %b want 1", o_overflow); else n_pass++;
    n_chk++; if (o_count !== CW'(4)) $display("FAIL stall_count_after_drop: got %0d want 4", o_count); else n_pass++;
    for (int j = 0; j < 6; j++) begin
      n_chk++;
      if (o_valid !== (j < 4)) $display("FAIL stall_drain_valid %0d: got %b want %b", j, o_valid, (j < 4));
      else n_pass++;
      if (j < 4) begin
        n_chk++;
        if (o_data !== rows[j]) $display("FAIL stall_drain_data %0d: got %h want %h", j, o_data, rows[j]);
        else n_pass++;
      end
      tick(1'b0, '0, 1'b1);
    end
    n_chk++; if (o_overflow !== 1'b1) $display("FAIL stall_ovf_sticky: got %b want 1", o_overflow); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] rows [5];
    for (int r = 0; r < 5; r++) rows[r] = rand_row();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        n_chk++; if (o_count !== CW'(4)) $display("FAIL pp_full: got %0d want 4", o_count); else n_pass++;
        n_chk++; if (o_data !== rows[0]) $display("FAIL pp_head0: got %h want %h", o_data, rows[0]); else n_pass++;
      end
      tick(k < 5, (k < 5) ? rows[k] : '0, k == 7);
    end
    n_chk++; if (o_count !== CW'(4)) $display("FAIL pp_count: got %0d want 4", o_count); else n_pass++;
    n_chk++; if (o_overflow !== 1'b0) $display("FAIL pp_ovf: got %b want 0", o_overflow); else n_pass++;
    for (int j = 0; j < 5; j++) begin
      n_chk++;
      if (o_valid !== (j < 4)) $display("FAIL pp_drain_valid %0d: got %b want %b", j, o_valid, (j < 4));
      else n_pass++;
      if (j < 4) begin
        n_chk++;
        if (o_data !== rows[j+1]) $display("FAIL pp_drain_data %0d: got %h want %h", j, o_data, rows[j+1]);
        else n_pass++;
      end
      tick(1'b0, '0, 1'b1);
    end
    // Twelve more rows through the FIFO so both pointers wrap several times.
    for (int k = 0; k < 20; k++) begin
      n_chk++;
      if (o_valid !== (mq.size() != 0)) $display("FAIL wrap_valid cyc%0d: got %b want %b", k, o_valid, (mq.size() != 0));
      else n_pass++;
      if (mq.size() != 0) begin
        n_chk++;
        if (o_data !== mq[0]) $display("FAIL wrap_data cyc%0d: got %h want %h", k, o_data, mq[0]);
        else n_pass++;
      end
      tick(k < 12, rand_row(), (k % 3) != 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] row;
    do_reset();
    for (int k = 0; k < 5; k++) tick(k == 0 || k == 1 || k == 3 || k == 4, rand_row(), 1'b0);
    n_chk++; if (o_count !== CW'(2)) $display("FAIL mid_pre_count: got %0d want 2", o_count); else n_pass++;
    do_reset();
    n_chk++; if (o_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", o_valid); else n_pass++;
    n_chk++; if (o_count !== '0) $display("FAIL mid_count: got %0d want 0", o_count); else n_pass++;
    n_chk++; if (o_data !== '0) $display("FAIL mid_data: got %h want 0", o_data); else n_pass++;
    n_chk++; if (o_overflow !== 1'b0) $display("FAIL mid_ovf: got %b want 0", o_overflow); else n_pass++;
    row = rand_row();
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (o_valid !== (k == 4)) $display("FAIL mid_after cyc%0d: got %b want %b", k, o_valid, (k == 4));
      else n_pass++;
      if (k == 4) begin
        n_chk++;
        if (o_data !== row) $display("FAIL mid_row: got %h want %h", o_data, row);
        else n_pass++;
      end
      tick(k == 0, row, 1'b1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      n_chk++;
      if (o_count !== CW'(mq.size())) $display("FAIL rnd_count cyc%0d: got %0d want %0d", k, o_count, mq.size());
      else n_pass++;
      n_chk++;
      if (o_valid !== (mq.size() != 0)) $display("FAIL rnd_valid cyc%0d: got %b want %b", k, o_valid, (mq.size() != 0));
      else n_pass++;
      n_chk++;
      if (o_data !== ((mq.size() != 0) ? mq[0] : '0)) $display("FAIL rnd_data cyc%0d: got %h want %h", k, o_data, (mq.size() != 0) ? mq[0] : '0);
      else n_pass++;
      n_chk++;
      if (o_overflow !== movf) $display("FAIL rnd_ovf cyc%0d: got %b want %b", k, o_overflow, movf);
      else n_pass++;
      tick(1'($urandom), rand_row(), 1'($urandom));
    end
  endtask

  initial begin
    for (int k = 0; k < COLS; k++) begin
      hv[k] = 1'b0;
      hr[k] = '0;
    end
    movf = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_streaming();
    test_fill_stall();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
